// File: rtl/sag4fun_host.sv
// Request front-end for a sequential SAG4Fun32S core: caches the loaded mask, issues ldm on a
// mask change, forwards the data operation and returns the result with a completion watchdog.
module sag4fun_host #(
  parameter int unsigned Timeout = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_inv_i,
  input  logic        req_msk_i,
  input  logic [31:0] req_data_i,
  input  logic [31:0] req_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [15:0] mask_loads_o,
  output logic        sag_inv_o,
  output logic        sag_msk_o,
  output logic        sag_ldm_o,
  output logic        sag_start_o,
  output logic [31:0] sag_din_o,
  input  logic        sag_ready_i,
  input  logic [31:0] sag_dout_i
);

  typedef enum logic [2:0] {
    StIdle,
    StLdmIssue,
    StLdmWait,
    StOpIssue,
    StOpWait,
    StResp
  } state_e;

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            inv_q, inv_d;
  logic            msk_q, msk_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     mask_q, mask_d;
  logic            cache_valid_q, cache_valid_d;
  logic [31:0]     cache_mask_q, cache_mask_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [15:0]     mask_loads_q, mask_loads_d;
  logic            sag_inv_q, sag_inv_d;
  logic            sag_msk_q, sag_msk_d;
  logic            sag_ldm_q, sag_ldm_d;
  logic [31:0]     sag_din_q, sag_din_d;
  logic            wd_expired;
  logic            cache_hit;

  // Counter value of TIMEOUT-1 means this is the TIMEOUT-th cycle spent in the state.
  assign wd_expired = (Timeout != 0) && (wd_cnt_q == CntW'(Timeout - 1));
  assign cache_hit  = cache_valid_q && (req_mask_i == cache_mask_q) && !flush_i;

  always_comb begin
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q + CntW'(1);
    inv_d         = inv_q;
    msk_d         = msk_q;
    data_d        = data_q;
    mask_d        = mask_q;
    cache_valid_d = cache_valid_q;
    cache_mask_d  = cache_mask_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    mask_loads_d  = mask_loads_q;
    sag_inv_d     = sag_inv_q;
    sag_msk_d     = sag_msk_q;
    sag_ldm_d     = sag_ldm_q;
    sag_din_d     = sag_din_q;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          inv_d    = req_inv_i;
          msk_d    = req_msk_i;
          data_d   = req_data_i;
          mask_d   = req_mask_i;
          wd_cnt_d = '0;
          if (cache_hit) begin
            state_d   = StOpIssue;
            sag_ldm_d = 1'b0;
            sag_inv_d = req_inv_i;
            sag_msk_d = req_msk_i;
            sag_din_d = req_data_i;
          end else begin
            state_d   = StLdmIssue;
            sag_ldm_d = 1'b1;
            sag_inv_d = 1'b0;
            sag_msk_d = 1'b0;
            sag_din_d = req_mask_i;
          end
        end
      end
      StLdmIssue, StOpIssue: begin
        if (sag_ready_i) begin
          state_d  = (state_q == StLdmIssue) ? StLdmWait : StOpWait;
          wd_cnt_d = '0;
        end else if (wd_expired) begin
          state_d       = StResp;
          rsp_err_d     = 1'b1;
          rsp_data_d    = '0;
          cache_valid_d = 1'b0;
        end
      end
      StLdmWait: begin
        if (sag_ready_i) begin
          state_d       = StOpIssue;
          wd_cnt_d      = '0;
          cache_valid_d = 1'b1;
          cache_mask_d  = mask_q;
          if (mask_loads_q != 16'hFFFF) begin
            mask_loads_d = mask_loads_q + 16'd1;
          end
          sag_ldm_d = 1'b0;
          sag_inv_d = inv_q;
          sag_msk_d = msk_q;
          sag_din_d = data_q;
        end else if (wd_expired) begin
          state_d       = StResp;
          rsp_err_d     = 1'b1;
          rsp_data_d    = '0;
          cache_valid_d = 1'b0;
        end
      end
      StOpWait: begin
        if (sag_ready_i) begin
          state_d    = StResp;
          rsp_data_d = sag_dout_i;
          rsp_err_d  = 1'b0;
        end else if (wd_expired) begin
          state_d       = StResp;
          rsp_err_d     = 1'b1;
          rsp_data_d    = '0;
          cache_valid_d = 1'b0;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides any cache fill happening on the same edge.
    if (flush_i) begin
      cache_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      wd_cnt_q      <= '0;
      inv_q         <= 1'b0;
      msk_q         <= 1'b0;
      data_q        <= '0;
      mask_q        <= '0;
      cache_valid_q <= 1'b0;
      cache_mask_q  <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      mask_loads_q  <= '0;
      sag_inv_q     <= 1'b0;
      sag_msk_q     <= 1'b0;
      sag_ldm_q     <= 1'b0;
      sag_din_q     <= '0;
    end else begin
      state_q       <= state_d;
      wd_cnt_q      <= wd_cnt_d;
      inv_q         <= inv_d;
      msk_q         <= msk_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      cache_valid_q <= cache_valid_d;
      cache_mask_q  <= cache_mask_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      mask_loads_q  <= mask_loads_d;
      sag_inv_q     <= sag_inv_d;
      sag_msk_q     <= sag_msk_d;
      sag_ldm_q     <= sag_ldm_d;
      sag_din_q     <= sag_din_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign rsp_valid_o  = (state_q == StResp);
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign mask_loads_o = mask_loads_q;
  assign sag_start_o  = (state_q == StLdmIssue) || (state_q == StOpIssue);
  assign sag_inv_o    = sag_inv_q;
  assign sag_msk_o    = sag_msk_q;
  assign sag_ldm_o    = sag_ldm_q;
  assign sag_din_o    = sag_din_q;

endmodule

// File: tb/tb_sag4fun_host.sv
// Directed bench for sag4fun_host with a behavioural core that can act combinational,
// sequential (busy 4 cycles) or hung after its start handshake.
module tb_sag4fun_host;

  localparam logic [31:0] M1 = 32'h690AEA75;
  localparam logic [31:0] M2 = 32'hF0F0F0F0;
  localparam logic [31:0] D1 = 32'hB3389E39;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, req_inv, req_msk;
  logic [31:0] req_data, req_mask, rsp_data, sag_din, sag_dout;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] mask_loads;
  logic        sag_inv, sag_msk, sag_ldm, sag_start, sag_ready;

  always #5 clk = ~clk;

  sag4fun_host #(.Timeout(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_inv_i    (req_inv),
    .req_msk_i    (req_msk),
    .req_data_i   (req_data),
    .req_mask_i   (req_mask),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .mask_loads_o (mask_loads),
    .sag_inv_o    (sag_inv),
    .sag_msk_o    (sag_msk),
    .sag_ldm_o    (sag_ldm),
    .sag_start_o  (sag_start),
    .sag_din_o    (sag_din),
    .sag_ready_i  (sag_ready),
    .sag_dout_i   (sag_dout)
  );

  // Core model: reference results for the known vector, a simple mix otherwise.
  function automatic logic [31:0] core_fn(logic [31:0] m, logic inv, logic msk, logic [31:0] d);
    if (m == M1 && d == D1 && !msk) return inv ? 32'h43CF83E3 : 32'h4CCB5A6D;
    return {d[15:0], d[31:16]} ^ m ^ (inv ? 32'hFFFF0000 : 32'h0) ^ (msk ? 32'h0000FFFF : 32'h0);
  endfunction

  int          mode = 0;  // 0 combinational, 1 sequential B=4, 2 hangs after start
  int          busy = 0;
  logic        stuck = 1'b0;
  logic [31:0] core_mask = '0;
  logic [31:0] seq_out = '0;
  logic [31:0] ldm_din = '0;
  int          ldm_seen = 0;

  always @(posedge clk) begin
    if (sag_start && sag_ready) begin
      if (sag_ldm) begin
        core_mask <= sag_din;
        ldm_din   <= sag_din;
        ldm_seen  <= ldm_seen + 1;
      end else begin
        seq_out <= core_fn(core_mask, sag_inv, sag_msk, sag_din);
      end
      if (mode == 1) busy <= 4;
      if (mode == 2) stuck <= 1'b1;
    end else if (mode == 0) begin
      busy <= 0;
    end else if (busy > 0) begin
      busy <= busy - 1;
    end
    if (mode != 2) stuck <= 1'b0;
  end

  assign sag_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (busy == 0) : !stuck;
  assign sag_dout  = (mode == 0) ? core_fn(core_mask, sag_inv, sag_msk, sag_din) : seq_out;

  typedef struct {
    int          mode;
    logic        inv;
    logic        msk;
    logic        flush;
    logic [31:0] data;
    logic [31:0] mask;
    int          lat;
    int          ldm;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] loads;
    int          hold;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cur   = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %h want %h", name, cur, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v);
    int   lat;
    int   ldm0;
    bit   got;
    bit   stable;
    mode = v.mode;
    got  = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (req_ready) got = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("req_ready_before_accept", {31'b0, got}, 32'd1);
    req_valid = 1'b1;
    req_inv   = v.inv;
    req_msk   = v.msk;
    req_data  = v.data;
    req_mask  = v.mask;
    flush     = v.flush;
    ldm0      = ldm_seen;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) got = 1;
    end
    chk("rsp_valid_seen", {31'b0, got}, 32'd1);
    chk("latency", lat, v.lat);
    chk("rsp_data", rsp_data, v.rdata);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.err});
    chk("mask_loads", {16'b0, mask_loads}, {16'b0, v.loads});
    chk("ldm_issued", ldm_seen - ldm0, v.ldm);
    if (v.ldm != 0) chk("ldm_din", ldm_din, v.mask);
    chk("sag_din_held", sag_din, v.data);
    chk("sag_start_idle", {31'b0, sag_start}, 32'd0);
    if (v.hold > 0) begin
      stable = 1;
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk);
        #1;
        if (!rsp_valid || rsp_data !== v.rdata || rsp_err !== v.err || req_ready) stable = 0;
      end
      chk("backpressure_stable", {31'b0, stable}, 32'd1);
    end
    rsp_ready = 1'b1;
    chk("req_ready_during_rsp_hs", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("req_ready_after_rsp_hs", {31'b0, req_ready}, 32'd1);
    chk("rsp_valid_after_rsp_hs", {31'b0, rsp_valid}, 32'd0);
  endtask

  function automatic vec_t mk(int md, logic inv, logic msk, logic fl, logic [31:0] d,
                              logic [31:0] m, int lat, int ldm, logic [31:0] rd, logic err,
                              logic [15:0] loads, int hold);
    vec_t v;
    v.mode = md; v.inv = inv; v.msk = msk; v.flush = fl; v.data = d; v.mask = m;
    v.lat = lat; v.ldm = ldm; v.rdata = rd; v.err = err; v.loads = loads; v.hold = hold;
    return v;
  endfunction

  vec_t vt[9];

  initial begin
    vt[0] = mk(1, 0, 0, 0, D1, M1, 12, 1, 32'h4CCB5A6D, 0, 16'd1, 0);
    vt[1] = mk(1, 1, 0, 0, D1, M1, 6, 0, 32'h43CF83E3, 0, 16'd1, 0);
    vt[2] = mk(0, 0, 1, 0, 32'h12345678, M1, 2, 0, core_fn(M1, 0, 1, 32'h12345678), 0, 16'd1, 0);
    vt[3] = mk(0, 0, 0, 0, 32'hCAFEBABE, M2, 4, 1, core_fn(M2, 0, 0, 32'hCAFEBABE), 0, 16'd2, 0);
    vt[4] = mk(0, 1, 0, 1, 32'h0F1E2D3C, M2, 4, 1, core_fn(M2, 1, 0, 32'h0F1E2D3C), 0, 16'd3, 0);
    vt[5] = mk(0, 1, 1, 0, 32'hA5A55A5A, M2, 2, 0, core_fn(M2, 1, 1, 32'hA5A55A5A), 0, 16'd3, 10);
    vt[6] = mk(1, 0, 0, 0, 32'h00C0FFEE, M1, 12, 1, core_fn(M1, 0, 0, 32'h00C0FFEE), 0, 16'd4, 0);
    vt[7] = mk(2, 0, 0, 0, 32'hDEADBEEF, M1, 9, 0, 32'h0, 1, 16'd4, 0);
    vt[8] = mk(0, 1, 0, 0, 32'h0BADF00D, M1, 4, 1, core_fn(M1, 1, 0, 32'h0BADF00D), 0, 16'd5, 0);

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_inv = 1'b0; req_msk = 1'b0;
    req_data = '0; req_mask = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_mask_loads", {16'b0, mask_loads}, 32'd0);
    chk("reset_sag_ctrl", {28'b0, sag_start, sag_inv, sag_msk, sag_ldm}, 32'd0);
    chk("reset_sag_din", sag_din, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cur = i;
      do_req(vt[i]);
    end

    // Reset while the core is busy in OP_WAIT (cache holds M1, so this is a hit).
    cur = 100;
    mode = 1;
    req_valid = 1'b1; req_inv = 1'b0; req_msk = 1'b0; req_data = 32'h13579BDF; req_mask = M1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("in_op_wait_no_rsp", {30'b0, sag_start, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midop_reset_sag_start", {31'b0, sag_start}, 32'd0);
    chk("midop_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midop_reset_mask_loads", {16'b0, mask_loads}, 32'd0);
    chk("midop_reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midop_reset_sag_din", sag_din, 32'd0);
    repeat (6) @(posedge clk);
    #1;

    // Saturation: preload the counter, then one more miss must not wrap.
    cur = 101;
    force dut.mask_loads_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.mask_loads_q;
    do_req(mk(0, 0, 0, 0, 32'h2468ACE0, M1, 4, 1, core_fn(M1, 0, 0, 32'h2468ACE0), 0,
              16'hFFFF, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/sag4fun_host.md
# sag4fun_host

Request front-end that sits in front of a sequential SAG4Fun32S sheep-and-goats core and drives the core's control port on behalf of the rest of the design. It accepts one operation at a time over a valid/ready request channel and caches the last mask loaded into the core. On a mask change it issues a mask-load (ldm) operation before the data operation. It returns the core's result on a valid/ready response channel, and a watchdog flags a core that never completes.

## Interface
- TIMEOUT, 64: maximum wait cycles for core completion per operation; 0 disables the watchdog.
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  single-cycle pulse; invalidates the mask cache
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_inv  in  1  0 = SAG, 1 = inverse (ISG)
- req_msk  in  1  forwarded to core ctrl_msk unchanged
- req_data  in  32  operand
- req_mask  in  32  mask for this operation
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  core result; 0 on error
- rsp_err  out  1  watchdog expired
- mask_loads  out  16  count of ldm operations issued, saturating at 0xFFFF
- sag_inv, sag_msk, sag_ldm, sag_start  out  1 each  to core ctrl_inv/ctrl_msk/ctrl_ldm/ctrl_start
- sag_din  out  32  to core in_data
- sag_ready  in  1  from core ctrl_ready
- sag_dout  in  32  from core out_data

## Operation
- States: IDLE, LDM_ISSUE, LDM_WAIT, OP_ISSUE, OP_WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch inv/msk/data/mask.
  - Cache hit (cache valid and req_mask equals the cached mask): go to OP_ISSUE.
  - Otherwise: go to LDM_ISSUE.
- LDM_ISSUE: drive sag_start=1, sag_ldm=1, sag_inv=0, sag_msk=0, sag_din=latched mask.
  - Handshake occurs on an edge with sag_start and sag_ready both high.
  - After the handshake, go to LDM_WAIT.
- LDM_WAIT: sag_start=0; all other core inputs held.
  - On the first edge with sag_ready=1: load the cache with the mask, set the cache valid, increment mask_loads, go to OP_ISSUE.
  - sag_dout is ignored.
- OP_ISSUE: drive sag_start=1, sag_ldm=0, sag_inv=latched inv, sag_msk=latched msk, sag_din=latched data. After the handshake, go to OP_WAIT.
- OP_WAIT: on the first edge with sag_ready=1, register sag_dout into rsp_data, set rsp_err=0, go to RESP.
- RESP: rsp_valid=1. Go to IDLE on an edge with rsp_ready=1.
- Core inputs are never driven to X.
  - They hold their last value from issue through capture, so a combinational core (sag_ready tied 1) sees stable in_data when sampled.
  - In IDLE they hold their previous value; sag_start=0.
- Watchdog (TIMEOUT>0):
  - The counter clears on entry to each ISSUE and WAIT state and counts cycles spent in that state.
  - Reaching TIMEOUT goes to RESP with rsp_err=1, rsp_data=0, and clears the cache valid bit.
- flush:
  - Clears the cache valid bit on the next edge.
  - If flush coincides with request acceptance, that request is treated as a miss.
  - During LDM_WAIT completion, flush wins and the cache ends invalid. The load still counts in mask_loads.
- rsp_data and rsp_err hold while rsp_valid=1 and rsp_ready=0.

## Timing
- Reset values:
  - State IDLE, cache invalid, cached mask 0.
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, mask_loads=0.
  - sag_start=0, sag_inv=0, sag_msk=0, sag_ldm=0, sag_din=0.
- Reset mid-operation: the next edge returns to the reset state. A core operation already in flight is abandoned.
- Latency with a combinational core (sag_ready=1), counted from the accept edge E0:
  - Hit: issue at E1, capture at E2, rsp_valid high from E2, i.e. 2 cycles.
  - Miss: 4 cycles.
- With a sequential core of busy length B (sag_ready low for B cycles after its start edge), each phase adds B cycles.
- sag_start is high for at least one cycle and stays high until sag_ready is sampled high.
- A new request is not accepted in the same cycle as the response handshake; req_ready rises the cycle after.

## Test plan
- Miss then hit (sequential core model, B=4; vectors below):
  - req_mask=0x690AEA75, req_data=0xB3389E39, inv=0 -> ldm issued with sag_din=0x690AEA75, then rsp_data=0x4CCB5A6D, rsp_err=0, mask_loads=1.
  - Same mask with inv=1 -> no ldm issued, rsp_data=0x43CF83E3, mask_loads stays 1.
- Combinational core (sag_ready tied 1):
  - Hit -> rsp_valid 2 cycles after accept.
  - Miss -> 4 cycles after accept.
  - sag_din is stable in the capture cycle.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout; one cycle after rsp_ready=1, req_ready=1.
- Watchdog: TIMEOUT=8 with sag_ready stuck low after the start handshake -> rsp_err=1 and rsp_data=0 exactly 8 cycles after entering WAIT; the next request with the same mask reissues ldm.
- Flush and reset:
  - flush coincident with request acceptance -> ldm reissued.
  - Reset asserted in OP_WAIT -> next cycle sag_start=0, rsp_valid=0, mask_loads=0, req_ready=1.
  - Saturation: mask_loads forced to 0xFFFF then one more miss -> stays 0xFFFF.
